// File: rtl/alu_execute_if.sv
// Request/response bundle between the decode stage and the execute stage.
interface alu_execute_if #(
  parameter int unsigned DATA_W = 6
);
  logic                  start;
  logic [2:0]            instruction;
  logic [DATA_W-1:0]     a;
  logic [DATA_W-1:0]     b;
  logic [2*DATA_W-1:0]   result;
  logic                  carry;
  logic                  zero;
  logic                  err;
  logic                  busy;
  logic                  done;

  modport master (
    output start, instruction, a, b,
    input  result, carry, zero, err, busy, done
  );

  modport slave (
    input  start, instruction, a, b,
    output result, carry, zero, err, busy, done
  );
endinterface

// File: rtl/alu_execute.sv
// Multi-cycle ALU execute stage: single-cycle logic ops, shift-add MUL and
// restoring DIV. Define ALU_DIV_EN to build the divider; otherwise op 111 reports err.
module alu_execute #(
  parameter int unsigned DATA_W = 6
) (
  input  logic           clk,
  input  logic           rst_n,
  alu_execute_if.slave   bus
);
  localparam int unsigned RES_W = 2 * DATA_W;
  localparam int unsigned CNT_W = $clog2(DATA_W);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_EXEC = 3'd1;
  localparam logic [2:0] S_MUL  = 3'd2;
`ifdef ALU_DIV_EN
  localparam logic [2:0] S_DIV  = 3'd3;
  localparam logic [2:0] OP_DIV = 3'b111;
`endif
  localparam logic [2:0] S_DONE = 3'd4;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_NOT = 3'b101;
  localparam logic [2:0] OP_MUL = 3'b110;

  logic [2:0]        state_q,  state_d;
  logic [2:0]        op_q,     op_d;
  logic [DATA_W-1:0] a_q,      a_d;
  logic [DATA_W-1:0] b_q,      b_d;
  logic [CNT_W-1:0]  cnt_q,    cnt_d;
  logic [RES_W-1:0]  acc_q,    acc_d;
  logic [RES_W-1:0]  result_q, result_d;
  logic              carry_q,  carry_d;
  logic              zero_q,   zero_d;
  logic              err_q,    err_d;
  logic              busy_q,   busy_d;
  logic              done_q,   done_d;

  logic              wr_en;
  logic [RES_W-1:0]  res_w;
  logic              carry_w;
  logic              err_w;
  logic [DATA_W:0]   sum;
  logic [RES_W-1:0]  mul_step;

  assign sum      = (DATA_W+1)'(a_q) + (DATA_W+1)'(b_q);
  assign mul_step = acc_q + (b_q[cnt_q] ? (RES_W'(a_q) << cnt_q) : RES_W'(0));

`ifdef ALU_DIV_EN
  // One restoring step: acc holds {remainder, partial quotient}, dividend bits enter MSB first.
  logic [CNT_W-1:0]  div_idx;
  logic [DATA_W:0]   trial;
  logic              div_ge;
  logic [DATA_W-1:0] rem_n;
  logic [RES_W-1:0]  div_step;

  assign div_idx  = CNT_W'(DATA_W - 1) - cnt_q;
  assign trial    = {acc_q[RES_W-1:DATA_W], a_q[div_idx]};
  assign div_ge   = (trial >= {1'b0, b_q});
  assign rem_n    = div_ge ? DATA_W'(trial - {1'b0, b_q}) : trial[DATA_W-1:0];
  assign div_step = {rem_n, acc_q[DATA_W-2:0], div_ge};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      cnt_q    <= '0;
      acc_q    <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      zero_q   <= zero_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    result_d = result_q;
    carry_d  = carry_q;
    zero_d   = zero_q;
    err_d    = err_q;
    wr_en    = 1'b0;
    res_w    = '0;
    carry_w  = 1'b0;
    err_w    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          op_d  = bus.instruction;
          a_d   = bus.a;
          b_d   = bus.b;
          cnt_d = '0;
          acc_d = '0;
          if (bus.instruction == OP_MUL) state_d = S_MUL;
`ifdef ALU_DIV_EN
          else if (bus.instruction == OP_DIV) state_d = S_DIV;
`endif
          else state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        wr_en   = 1'b1;
        state_d = S_DONE;
        case (op_q)
          OP_ADD: begin
            res_w   = RES_W'(sum);
            carry_w = sum[DATA_W];
          end
          OP_SUB: begin
            res_w   = {{DATA_W{1'b0}}, a_q - b_q};
            carry_w = (a_q < b_q);
          end
          OP_AND:  res_w = {{DATA_W{1'b0}}, a_q & b_q};
          OP_OR:   res_w = {{DATA_W{1'b0}}, a_q | b_q};
          OP_XOR:  res_w = {{DATA_W{1'b0}}, a_q ^ b_q};
          OP_NOT:  res_w = {{DATA_W{1'b0}}, ~a_q};
          default: err_w = 1'b1;
        endcase
      end
      S_MUL: begin
        acc_d = mul_step;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(DATA_W - 1)) begin
          wr_en   = 1'b1;
          res_w   = mul_step;
          state_d = S_DONE;
        end
      end
`ifdef ALU_DIV_EN
      S_DIV: begin
        if (b_q == '0) begin
          wr_en   = 1'b1;
          res_w   = {a_q, {DATA_W{1'b1}}};
          err_w   = 1'b1;
          state_d = S_DONE;
        end else begin
          acc_d = div_step;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(DATA_W - 1)) begin
            wr_en   = 1'b1;
            res_w   = div_step;
            state_d = S_DONE;
          end
        end
      end
`endif
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Result and flags change together, only on entry to DONE.
    if (wr_en) begin
      result_d = res_w;
      carry_d  = carry_w;
      err_d    = err_w;
      zero_d   = (res_w == '0);
    end

    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  assign bus.result = result_q;
  assign bus.carry  = carry_q;
  assign bus.zero   = zero_q;
  assign bus.err    = err_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
endmodule
